// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC PDM decimator.
package cic_pkg;

  localparam int unsigned CIC_ORDER         = 3;
  localparam int unsigned CIC_DEC_RATIO_DEF = 32;
  localparam int unsigned CIC_OUT_W_DEF     = 16;

  // Scaled output value plus a clip flag.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } cic_scaled_t;

  // Integrator/comb width: enough for the +/-R^3 full-scale comb output plus sign.
  function automatic int unsigned cic_acc_w(input int unsigned dec_ratio);
    return 2 + CIC_ORDER * $clog2(dec_ratio);
  endfunction

  // Align the comb output (range +/-2^(3L)) to out_w bits, then clip to the signed range.
  function automatic cic_scaled_t cic_scale_sat(input logic signed [63:0] v,
                                                input int unsigned       log2_r,
                                                input int unsigned       out_w);
    cic_scaled_t        res;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    int unsigned        msb;
    msb = CIC_ORDER * log2_r + 1;
    if (msb > out_w) begin
      s = v >>> (msb - out_w);
    end else begin
      s = v <<< (out_w - msb);
    end
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = s;
    if (s > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (s < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: y = u - u_delayed, advanced only on valid_in.
// Not gated by the block enable so in-flight samples always drain.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned W = cic_acc_w(CIC_DEC_RATIO_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [W-1:0] din,
  output logic         valid_out,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dout_q;
  logic         vld_q;

  // Differentiate on each valid input; the delay register tracks only valid inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= valid_in;
      if (valid_in) begin
        dout_q <= din - dly_q;
        dly_q  <= din;
      end
    end
  end

  assign valid_out = vld_q;
  assign dout      = dout_q;

endmodule

// File: rtl/cic_pdm_decimator.sv
// 3rd-order CIC decimator: 1-bit PDM stream in, signed PCM samples out.
// Optional build macro CIC_SETTLE_MASK_EN suppresses the first 3 post-reset samples.
module cic_pdm_decimator
  import cic_pkg::*;
#(
  parameter int unsigned DEC_RATIO = CIC_DEC_RATIO_DEF,
  parameter int unsigned OUT_W     = CIC_OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    pdm_en,
  input  logic                    pdm_in,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    sat
);

  localparam int unsigned LOG2R = $clog2(DEC_RATIO);
  localparam int unsigned ACC_W = cic_acc_w(DEC_RATIO);
  localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(DEC_RATIO - 1);

  logic             accept;
  logic             tick;
  logic [ACC_W-1:0] x;
  logic [LOG2R-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] i1_q, i1_d;
  logic [ACC_W-1:0] i2_q, i2_d;
  logic [ACC_W-1:0] i3_q, i3_d;
  logic [ACC_W-1:0] cap_q;
  logic             cap_vld_q;

  assign accept = en & pdm_en;
  assign tick   = accept & (cnt_q == CNT_LAST);
  // PDM 1 -> +1, 0 -> -1 (all ones in two's complement).
  assign x      = pdm_in ? ACC_W'(1) : '1;

  // Chained integrator update and bit counter; wrap-around is intended.
  always_comb begin
    cnt_d = cnt_q;
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    if (accept) begin
      cnt_d = cnt_q + LOG2R'(1);
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_d;
      i3_d  = i3_q + i2_d;
    end
  end

  // Integrator/counter state; the tick captures I3 including its own bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      cap_vld_q <= tick;
      if (tick) begin
        cap_q <= i3_d;
      end
    end
  end

  logic             c1_vld, c2_vld, c3_vld;
  logic [ACC_W-1:0] c1_dat, c2_dat, c3_dat;

  cic_comb_stage #(
    .W(ACC_W)
  ) u_comb1 (
    .clk      (clk),
    .rst      (rst),
    .valid_in (cap_vld_q),
    .din      (cap_q),
    .valid_out(c1_vld),
    .dout     (c1_dat)
  );

  cic_comb_stage #(
    .W(ACC_W)
  ) u_comb2 (
    .clk      (clk),
    .rst      (rst),
    .valid_in (c1_vld),
    .din      (c1_dat),
    .valid_out(c2_vld),
    .dout     (c2_dat)
  );

  cic_comb_stage #(
    .W(ACC_W)
  ) u_comb3 (
    .clk      (clk),
    .rst      (rst),
    .valid_in (c2_vld),
    .din      (c2_dat),
    .valid_out(c3_vld),
    .dout     (c3_dat)
  );

  logic [63:0] c3_ext;
  cic_scaled_t scaled;
  logic        unused_scaled;

  assign c3_ext        = {{(64 - ACC_W){c3_dat[ACC_W-1]}}, c3_dat};
  assign scaled        = cic_scale_sat(signed'(c3_ext), LOG2R, OUT_W);
  assign unused_scaled = ^scaled.val[63:OUT_W];

  logic masked;
  logic publish;

`ifdef CIC_SETTLE_MASK_EN
  logic [1:0] mask_cnt_q;

  assign masked = (mask_cnt_q != 2'd3);

  // Count the settling samples that leave the combs while history is still filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt_q <= '0;
    end else if (c3_vld && masked) begin
      mask_cnt_q <= mask_cnt_q + 2'd1;
    end
  end
`else
  assign masked = 1'b0;
`endif

  assign publish = c3_vld & ~masked;

  logic signed [OUT_W-1:0] sample_q;
  logic                    valid_q;
  logic                    sat_q;

  // Output register: sample held between strobes, sat only alongside the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      valid_q <= publish;
      sat_q   <= publish & scaled.sat;
      if (publish) begin
        sample_q <= scaled.val[OUT_W-1:0];
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Self-checking bench for cic_pdm_decimator against a direct-convolution CIC model.
`timescale 1ns/1ps
module tb_cic_pdm_decimator;

  localparam int R     = 32;
  localparam int L     = 5;
  localparam int OUT_W = 16;
  localparam int HLEN  = 3 * R - 2;
`ifdef CIC_SETTLE_MASK_EN
  localparam int MASK_N = 3;
`else
  localparam int MASK_N = 0;
`endif

  typedef struct packed {
    int          cyc;
    logic [15:0] val;
    logic        sat;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    pdm_en = 1'b0;
  logic                    pdm_in = 1'b0;
  logic signed [OUT_W-1:0] sample_out;
  logic                    sample_valid;
  logic                    sat;

  always #5 clk = ~clk;

  cic_pdm_decimator #(
    .DEC_RATIO(R),
    .OUT_W    (OUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pdm_en      (pdm_en),
    .pdm_in      (pdm_in),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sat         (sat)
  );

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  mcnt = 0;
  int  mask_left = MASK_N;
  int  stray_sat = 0;
  int  last_tick = -1;
  int  h[HLEN];
  int  hist[$];
  ev_t exp_q[$];
  ev_t obs_q[$];

  // Impulse response of the cascade of three length-R moving sums.
  task automatic build_h;
    int a[HLEN];
    int b[HLEN];
    for (int i = 0; i < HLEN; i++) a[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < 3; s++) begin
      for (int n = 0; n < HLEN; n++) begin
        b[n] = 0;
        for (int k = 0; k < R; k++) if (n - k >= 0) b[n] += a[n - k];
      end
      a = b;
    end
    h = a;
  endtask

  // Expected sample: convolve recent accepted bits with h, align, clip.
  function automatic ev_t ref_event(input int due);
    longint y;
    longint s;
    longint hi;
    longint lo;
    int     sh;
    ev_t    e;
    y = 0;
    for (int k = 0; k < HLEN; k++)
      if (k < hist.size()) y += longint'(h[k]) * hist[hist.size() - 1 - k];
    sh = 3 * L + 1 - OUT_W;
    s  = (sh >= 0) ? (y >>> sh) : (y <<< -sh);
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    e.cyc = due;
    e.sat = (s > hi) || (s < lo);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    e.val = 16'(s);
    return e;
  endfunction

  // One clock: drive inputs, advance the model at the edge, record outputs 1ns later.
  task automatic step(input logic r, input logic e, input logic pe, input logic pi);
    ev_t ev;
    rst    = r;
    en     = e;
    pdm_en = pe;
    pdm_in = pi;
    @(posedge clk);
    cyc++;
    if (r) begin
      hist.delete();
      mcnt      = 0;
      mask_left = MASK_N;
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    end else if (e && pe) begin
      hist.push_back(pi ? 1 : -1);
      if (hist.size() > HLEN) void'(hist.pop_front());
      mcnt++;
      if (mcnt == R) begin
        mcnt      = 0;
        last_tick = cyc;
        if (mask_left > 0) mask_left--;
        else exp_q.push_back(ref_event(cyc + 4));
      end
    end
    #1;
    if (sample_valid === 1'b1) begin
      ev.cyc = cyc;
      ev.val = sample_out;
      ev.sat = sat;
      obs_q.push_back(ev);
    end
    if (sat === 1'b1 && sample_valid !== 1'b1) stray_sat++;
  endtask

  task automatic do_reset;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    obs_q.delete();
    exp_q.delete();
    stray_sat = 0;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset sample_out: got %0d expected 0", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset sample_valid: got %b expected 0", sample_valid);
    end
    checks++;
    if (sat !== 1'b0) begin
      errors++;
      $display("FAIL reset sat: got %b expected 0", sat);
    end
  endtask

  // Constant one, constant zero and alternating bits, pdm_en every 4th cycle.
  task automatic test_patterns;
    string names[3]    = '{"const_one", "const_zero", "alternating"};
    int    last_val[3] = '{32767, -32768, 0};
    logic  last_sat[3] = '{1'b1, 1'b0, 1'b0};
    logic  pi;
    for (int kind = 0; kind < 3; kind++) begin
      do_reset();
      for (int n = 0; n < 6 * R; n++) begin
        pi = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : ((n % 2) == 0);
        step(1'b0, 1'b1, 1'b1, pi);
        repeat (3) step(1'b0, 1'b1, 1'b0, pi);
      end
      repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_q.size() !== exp_q.size() || obs_q.size() !== 6 - MASK_N) begin
        errors++;
        $display("FAIL %s pulse count: got %0d expected %0d (model %0d)", names[kind],
                 obs_q.size(), 6 - MASK_N, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s sample %0d: got cyc=%0d val=%0d sat=%b expected cyc=%0d val=%0d sat=%b",
                   names[kind], i, obs_q[i].cyc, $signed(obs_q[i].val), obs_q[i].sat,
                   exp_q[i].cyc, $signed(exp_q[i].val), exp_q[i].sat);
        end
      end
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s settled: got no samples expected %0d", names[kind], last_val[kind]);
      end else if ($signed(obs_q[$].val) !== last_val[kind] || obs_q[$].sat !== last_sat[kind]) begin
        errors++;
        $display("FAIL %s settled: got val=%0d sat=%b expected val=%0d sat=%b", names[kind],
                 $signed(obs_q[$].val), obs_q[$].sat, last_val[kind], last_sat[kind]);
      end
      checks++;
      if (sample_out !== last_val[kind]) begin
        errors++;
        $display("FAIL %s hold: got %0d expected %0d", names[kind], sample_out, last_val[kind]);
      end
    end
  endtask

  // pdm_en every cycle for 1000 cycles with random bits.
  task automatic test_back_to_back;
    int viol;
    do_reset();
    for (int n = 0; n < 1000; n++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== 31 - MASK_N || exp_q.size() !== 31 - MASK_N) begin
      errors++;
      $display("FAIL b2b pulse count: got %0d expected %0d (model %0d)", obs_q.size(),
               31 - MASK_N, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b sample %0d: got cyc=%0d val=%0d sat=%b expected cyc=%0d val=%0d sat=%b",
                 i, obs_q[i].cyc, $signed(obs_q[i].val), obs_q[i].sat,
                 exp_q[i].cyc, $signed(exp_q[i].val), exp_q[i].sat);
      end
    end
    viol = 0;
    for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].cyc - obs_q[i-1].cyc <= 1) viol++;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL b2b consecutive valid: got %0d adjacent pulses expected 0", viol);
    end
  endtask

  // Reset two cycles after a tick aborts that sample; next follows R bits later.
  task automatic test_reset_mid;
    int rst_cyc;
    do_reset();
    for (int n = 0; n < (MASK_N + 2) * R; n++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    rst_cyc = cyc;
    checks++;
    if (sample_out !== 16'sd0 || sample_valid !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid outputs: got out=%0d valid=%b sat=%b expected 0 0 0", sample_out,
               sample_valid, sat);
    end
    for (int n = 0; n < (MASK_N + 2) * R; n++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
      errors++;
      $display("FAIL rst_mid pulse count: got %0d expected 3 (model %0d)", obs_q.size(),
               exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid sample %0d: got cyc=%0d val=%0d sat=%b expected cyc=%0d val=%0d sat=%b",
                 i, obs_q[i].cyc, $signed(obs_q[i].val), obs_q[i].sat,
                 exp_q[i].cyc, $signed(exp_q[i].val), exp_q[i].sat);
      end
    end
    checks++;
    if (obs_q.size() < 2) begin
      errors++;
      $display("FAIL rst_mid first post-reset pulse: got none expected cyc=%0d",
               rst_cyc + (MASK_N + 1) * R + 4);
    end else if (obs_q[1].cyc !== rst_cyc + (MASK_N + 1) * R + 4) begin
      errors++;
      $display("FAIL rst_mid first post-reset pulse: got cyc=%0d expected cyc=%0d",
               obs_q[1].cyc, rst_cyc + (MASK_N + 1) * R + 4);
    end
  endtask

  // en low for 50 cycles mid-frame with a sample still in the combs.
  task automatic test_enable_hold;
    int lo_start;
    int lo_end;
    int in_win;
    do_reset();
    for (int n = 0; n < R + 2; n++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    lo_start = cyc + 1;
    for (int n = 0; n < 50; n++) step(1'b0, 1'b0, 1'(n % 2), 1'($urandom));
    lo_end = cyc;
    for (int n = 0; n < 3 * R - 2; n++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== 4 - MASK_N || exp_q.size() !== 4 - MASK_N) begin
      errors++;
      $display("FAIL en_hold pulse count: got %0d expected %0d (model %0d)", obs_q.size(),
               4 - MASK_N, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL en_hold sample %0d: got cyc=%0d val=%0d sat=%b expected cyc=%0d val=%0d sat=%b",
                 i, obs_q[i].cyc, $signed(obs_q[i].val), obs_q[i].sat,
                 exp_q[i].cyc, $signed(exp_q[i].val), exp_q[i].sat);
      end
    end
    in_win = 0;
    foreach (obs_q[i]) if (obs_q[i].cyc >= lo_start && obs_q[i].cyc <= lo_end) in_win++;
    checks++;
    if (in_win !== ((MASK_N == 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL en_hold drain during en low: got %0d pulses expected %0d", in_win,
               (MASK_N == 0) ? 1 : 0);
    end
    checks++;
    if (stray_sat !== 0) begin
      errors++;
      $display("FAIL en_hold sat without valid: got %0d cycles expected 0", stray_sat);
    end
  endtask

  initial begin
    build_h();
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_enable_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_pdm_decimator.md
Name: cic_pdm_decimator

Overview:
- 3rd-order CIC decimator that turns a 1-bit PDM microphone stream into 16-bit signed PCM samples.
- Sits directly upstream of the FIR/IIR filter stage.
- sample_out drives the filter's X input; sample_valid drives the filter's en input as a one-cycle sample-rate strobe.

Parameters:
- DEC_RATIO, 32, decimation factor R; power of two, 4..64.
- OUT_W, 16, output sample width (signed).
- ACC_W, 2+3*log2(DEC_RATIO), integrator/comb width; derived, not overridden (17 at default).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; when low, all state holds.
- pdm_en  input  1  PDM bit strobe; pdm_in is sampled only when pdm_en=1 and en=1.
- pdm_in  input  1  PDM data bit; 1 maps to +1, 0 maps to -1.
- sample_out  output  OUT_W  decimated signed PCM sample; held between strobes.
- sample_valid  output  1  one-cycle pulse when sample_out updates.
- sat  output  1  high with sample_valid when the current sample was clipped.

Behaviour:
- Reset (rst=1 at clock edge) clears:
  - 3 integrators, decimation counter, comb delay registers, pipeline valid bits;
  - sample_out=0, sample_valid=0, sat=0.
- Reset mid-operation aborts any in-flight sample; no sample_valid is produced for it.
- Integrators: on an accepted bit, I1+=x (x = ±1), I2+=I1_new, I3+=I2_new.
  - Update is chained combinationally within the cycle.
  - Arithmetic is two's-complement modulo 2^ACC_W; wrap-around is intended and cancelled by the combs. No saturation in integrators.
- Decimation counter:
  - Counts accepted bits 0..R-1.
  - The accepted bit at count R-1 is a decimation tick and wraps the count to 0.
  - The tick's own contribution is included in I3 before capture.
- Comb pipeline: 3 registered stages, each y = u - u_delayed, each with a valid bit.
  - Stage k loads on valid_{k-1}; its delay register updates only on valid_{k-1}.
  - Tick accepted at edge T → comb1 at T+1, comb2 at T+2, comb3 at T+3.
  - sample_out, sample_valid and sat register at T+4.
  - Fixed latency: 4 cycles from tick edge to sample_valid high.
- Output scaling (comb3 range is ±R^3 = ±2^(3L), where L = log2 R):
  - If 3L+1 > OUT_W: arithmetic shift right by (3L+1-OUT_W).
  - Otherwise: shift left by (OUT_W-3L-1).
  - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 if clipped.
  - At defaults: +32768 → 32767 with sat=1; -32768 passes unclipped.
- pdm_en may be asserted every cycle; the pipeline accepts back-to-back ticks because each stage is gated by its own valid bit.
- en=0: pdm_en is ignored, counter and integrators hold, but the comb pipeline keeps draining, so an in-flight sample still completes.
- sample_valid is never high on two consecutive cycles when R >= 2.

Optional Feature:
- Macro CIC_SETTLE_MASK_EN.
- Defined: after reset, the first 3 decimated samples (comb history not yet filled) are computed but sample_valid is suppressed. sample_out stays 0 and sat stays 0 for those samples. A 3-tick mask counter is cleared by rst.
- Undefined: every decimated sample pulses sample_valid, including the settling samples.

Decomposition:
- Package cic_pkg holds:
  - CIC_ORDER=3, default DEC_RATIO and OUT_W;
  - function computing ACC_W from DEC_RATIO;
  - signed saturate/scale function.
- One sub-module, cic_comb_stage, instantiated 3 times. It contains a registered differentiator with valid_in/valid_out, its own delay register, and clk/rst/en-free drain.
- Integrators, counter and output stage stay in the top module.

Test Plan:
- Constant pdm_in=1, pdm_en every 4th cycle, R=32:
  - sample_valid exactly once per 32 accepted bits, 4 cycles after the tick;
  - after settling, sample_out=32767 with sat=1.
- Constant pdm_in=0: after settling, sample_out=-32768 with sat=0.
- Alternating 1,0,1,0: after settling, sample_out=0 and sat=0.
- pdm_en every cycle for 1000 cycles: no lost or duplicated sample_valid (31 pulses for 992 accepted bits); latency still 4 cycles.
- rst pulsed 2 cycles after a tick:
  - no sample_valid for that tick; outputs 0;
  - next sample_valid follows exactly 32 accepted bits after rst deasserts.
- en low for 50 cycles mid-frame while pdm_en toggles: counter holds and the pending output still appears. With CIC_SETTLE_MASK_EN defined, the first 3 post-reset ticks produce no sample_valid.
